teras_result_buffer: RTL and testbench
======================================

# teras_result_buffer

Downstream consumer of the `teras` matrix engine's master port: captures matrix-C result words through the rts/rtr handshake into a power-of-two FIFO. It exposes them to the management core as Wishbone-readable registers: data pop, status, control, and a running result counter. Its Wishbone slave sits beside the engine's input bridge on the same user-project bus, decoded by address. It replaces the hard-wired `rtr_i = 1` tie-off, so no result is lost.

## Interface
- `DATA_W`, 32: result word width; equals the Wishbone data width.
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `CNT_W`, derived $clog2(DEPTH)+1: occupancy width.
- `clk` in 1: single clock, shared with Wishbone (`wb_clk_i`).
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `rts_i` in 1: engine result valid (engine `rts_o`).
- `rtr_o` out 1: ready to receive (engine `rtr_i`).
- `data_i` in DATA_W: result word (engine `data_o`).
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i` in 1: Wishbone classic strobes.
- `wbs_sel_i` in 4: byte selects. Ignored; full-word access only.
- `wbs_adr_i` in 4: word offset; bits [3:2] select the register.
- `wbs_dat_i` in 32: write data.
- `wbs_dat_o` out 32: read data, registered.
- `wbs_ack_o` out 1: single-cycle ack.

## Operation
- Push when `rts_i && rtr_o`. `rtr_o = (count != DEPTH)`, decoded from registered count only; no combinational path from Wishbone.
- The FIFO uses wrapping read/write pointers of $clog2(DEPTH) bits and a separate `count` register.
- Register map:
  - 0x0 DATA (RO): returns the head word and pops it.
  - 0x4 STATUS (RO): {16'b0, underflow[15], 6'b0, full[8], empty[7], 2'b0, count[4:0]}. count is zero-extended into [4:0] and limits DEPTH to ≤16 for this layout.
  - 0x8 CTRL (WO): bit0 flush, bit1 clear underflow.
  - 0xC TOTAL (RO): 32-bit count of accepted pushes; wraps at 2^32.
- Writes to RO registers and reads of CTRL are acked with no effect; CTRL reads return 0.
- DATA read with count==0 returns 0, sets sticky `underflow`, and does not pop.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- A flush clears pointers and count. A push in the same cycle is discarded and not added to TOTAL. TOTAL is cleared only by reset.
- Underflow set and clear in the same cycle: set wins.

## Timing
- Request accepted in cycle T when `cyc && stb && !ack`.
- `wbs_ack_o` and `wbs_dat_o` are registered and valid at T+1. Ack is high exactly one cycle and then low for at least one cycle, so back-to-back accepts are spaced 2 cycles apart.
- A pop, flush, or clear takes effect at the T→T+1 edge. DATA and STATUS values are sampled from the cycle-T state.
- A push at edge E is visible in STATUS and DATA for requests accepted at E+1 or later.
- `rtr_o` deasserts the cycle after the push that fills the FIFO. It reasserts the cycle after the first pop or flush from full.
- Reset values: `rtr_o`=1, `wbs_ack_o`=0, `wbs_dat_o`=0, count=0, pointers=0, underflow=0, TOTAL=0.
- Reset asserted mid-transaction: the ack is dropped immediately and all FIFO contents are lost.
- Memory contents are not reset.

## Structure
- `teras_pkg` holds the register offsets (`TERAS_RB_DATA/STATUS/CTRL/TOTAL`), the STATUS bit positions, and CTRL bit indices.
- One sub-module, `teras_sync_fifo` (DATA_W, DEPTH), with push/pop/flush, count, full, and empty.
- The top level holds the Wishbone decode, ack register, TOTAL, and underflow.

## Test plan
- Reset, then read STATUS → 0x0000_0080 (empty=1), `rtr_o`=1.
- Push 0x11, 0x22, 0x33, then 3 DATA reads → 0x11, 0x22, 0x33 in order. STATUS → empty; TOTAL → 3.
- Hold `rts_i` high for 10 cycles with incrementing data → exactly 8 accepted and `rtr_o`=0. STATUS → count 8, full=1. One DATA pop → `rtr_o`=1 next cycle, and the 9th word is accepted.
- DATA read when empty → 0x0, STATUS bit15=1. Write CTRL=0x2 → bit15 cleared.
- Fill 5 words, write CTRL=0x1 with a simultaneous push → count 0 and TOTAL unchanged by the discarded push.
- Push and pop in the same cycle at count=DEPTH-1, for 20 cycles → count stays constant, data order is preserved across pointer wrap, and there is no underflow.

Source files
------------

// File: rtl/teras_pkg.sv
// Shared constants for the teras result buffer: Wishbone register offsets,
// STATUS bit positions and CTRL bit indices.
package teras_pkg;

  // Register select values, taken from wbs_adr_i[3:2]
  localparam logic [1:0] TERAS_RB_DATA   = 2'd0;  // 0x0, RO, pop head word
  localparam logic [1:0] TERAS_RB_STATUS = 2'd1;  // 0x4, RO
  localparam logic [1:0] TERAS_RB_CTRL   = 2'd2;  // 0x8, WO
  localparam logic [1:0] TERAS_RB_TOTAL  = 2'd3;  // 0xC, RO, accepted pushes

  // STATUS layout: {16'b0, underflow, 6'b0, full, empty, 2'b0, count[4:0]}
  localparam int TERAS_STS_UNDERFLOW = 15;
  localparam int TERAS_STS_FULL      = 8;
  localparam int TERAS_STS_EMPTY     = 7;
  localparam int TERAS_STS_CNT_W     = 5;

  // CTRL write bits
  localparam int TERAS_CTRL_FLUSH  = 0;
  localparam int TERAS_CTRL_CLR_UF = 1;

endpackage

// File: rtl/teras_sync_fifo.sv
// Power-of-two synchronous FIFO with wrapping pointers and a separate
// occupancy counter. Pushes into a full FIFO and pops from an empty one are
// ignored; a flush wins over a push or pop in the same cycle.
module teras_sync_fifo #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 8,
  localparam int AW     = $clog2(DEPTH),
  localparam int CNT_W  = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic              i_flush,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_full,
  output logic              o_empty
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = i_push && !w_full  && !i_flush;
  assign w_pop   = i_pop  && !w_empty && !i_flush;

  // Storage write; the head word is read combinationally below
  // NOTE: the data array has no reset; count and pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and occupancy update; pointers wrap naturally at DEPTH
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = w_full;
  assign o_empty = w_empty;

endmodule

// File: rtl/teras_result_buffer.sv
// Captures teras result words via rts/rtr into a FIFO and exposes them to the
// management core through Wishbone registers: DATA pop, STATUS, CTRL, TOTAL.
module teras_result_buffer
  import teras_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 8,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rts_i,
  output logic              rtr_o,
  input  logic [DATA_W-1:0] data_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [3:0]        wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic [31:0]       wbs_dat_o,
  output logic              wbs_ack_o
);

  logic              r_ack;
  logic [31:0]       r_dat;
  logic [31:0]       r_total;
  logic              r_underflow;

  logic              w_req;
  logic              w_rd;
  logic              w_wr;
  logic [1:0]        w_sel;
  logic              w_flush;
  logic              w_clr_uf;
  logic              w_pop;
  logic              w_uf_set;
  logic              w_push_acc;
  logic [DATA_W-1:0] w_head;
  logic [CNT_W-1:0]  w_count;
  logic              w_full;
  logic              w_empty;
  logic [31:0]       w_status;
  logic [31:0]       w_rd_data;
  logic              w_unused;

  // Byte selects, low address bits and unused CTRL bits carry no meaning here
  assign w_unused = &{1'b0, wbs_sel_i, wbs_adr_i[1:0], wbs_dat_i[31:2]};

  // A request is taken only while ack is low, so accepts are two cycles apart
  assign w_req    = wbs_cyc_i && wbs_stb_i && !r_ack;
  assign w_rd     = w_req && !wbs_we_i;
  assign w_wr     = w_req &&  wbs_we_i;
  assign w_sel    = wbs_adr_i[3:2];
  assign w_flush  = w_wr && (w_sel == TERAS_RB_CTRL) && wbs_dat_i[TERAS_CTRL_FLUSH];
  assign w_clr_uf = w_wr && (w_sel == TERAS_RB_CTRL) && wbs_dat_i[TERAS_CTRL_CLR_UF];
  assign w_pop    = w_rd && (w_sel == TERAS_RB_DATA) && !w_empty;
  assign w_uf_set = w_rd && (w_sel == TERAS_RB_DATA) &&  w_empty;

  // rtr comes straight from the registered count, never from the bus
  assign rtr_o      = !w_full;
  assign w_push_acc = rts_i && rtr_o && !w_flush;

  teras_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (rts_i),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_data  (data_i),
    .o_data  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // STATUS word assembled from the current-cycle FIFO and sticky flag
  always_comb begin
    w_status                      = '0;
    w_status[TERAS_STS_UNDERFLOW] = r_underflow;
    w_status[TERAS_STS_FULL]      = w_full;
    w_status[TERAS_STS_EMPTY]     = w_empty;
    w_status[TERAS_STS_CNT_W-1:0] = TERAS_STS_CNT_W'(w_count);
  end

  // Read mux; CTRL and unmapped reads return zero
  // NOTE: the default assignment first keeps every path driven, so no latch is inferred.
  always_comb begin
    w_rd_data = '0;
    case (w_sel)
      TERAS_RB_DATA:   w_rd_data = w_empty ? 32'h0 : 32'(w_head);
      TERAS_RB_STATUS: w_rd_data = w_status;
      TERAS_RB_TOTAL:  w_rd_data = r_total;
      default:         w_rd_data = '0;
    endcase
  end

  // Wishbone ack and registered read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_req;
      if (w_rd)      r_dat <= w_rd_data;
      else if (w_wr) r_dat <= '0;
    end
  end

  // Running count of accepted results and sticky underflow (set beats clear)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_total     <= '0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push_acc) r_total <= r_total + 32'd1;
      if (w_uf_set)       r_underflow <= 1'b1;
      else if (w_clr_uf)  r_underflow <= 1'b0;
    end
  end

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;

endmodule

// File: tb/tb_teras_result_buffer.sv
// Self-checking bench for teras_result_buffer: directed vector table,
// hand-written multi-cycle sequences, and a randomized phase, all shadowed
// by a queue-based reference model checked every cycle.
module tb_teras_result_buffer;

  localparam int DEPTH = 8;

  logic        clk;
  logic        rst_n;
  logic        rts_i;
  logic        rtr_o;
  logic [31:0] data_i;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [3:0]  wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;

  int n_total = 0;
  int n_pass  = 0;

  teras_result_buffer #(.DATA_W(32), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rts_i     (rts_i),
    .rtr_o     (rtr_o),
    .data_i    (data_i),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_stb_i (wbs_stb_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_dat_o (wbs_dat_o),
    .wbs_ack_o (wbs_ack_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // ---------------- reference model: a queue plus counters ----------------
  logic [31:0] m_q [$];
  logic [31:0] m_total;
  logic        m_uf;
  logic        m_ack;
  logic        m_exp_rd;
  logic [31:0] m_exp_dat;

  function automatic logic [31:0] model_status(input int sz, input logic uf);
    logic [31:0] s;
    s = 32'(sz);
    if (sz == 0)     s = s | 32'h0000_0080;
    if (sz == DEPTH) s = s | 32'h0000_0100;
    if (uf)          s = s | 32'h0000_8000;
    return s;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_total   = 0;
      m_uf      = 0;
      m_ack     = 0;
      m_exp_rd  = 0;
      m_exp_dat = 0;
    end else begin
      int   sz;
      int   reg_i;
      logic req, rd, wr, flush, clr, push, pop;
      sz    = m_q.size();
      reg_i = int'(wbs_adr_i) / 4;
      req   = wbs_cyc_i && wbs_stb_i && !m_ack;
      rd    = req && !wbs_we_i;
      wr    = req &&  wbs_we_i;
      flush = wr && reg_i == 2 && wbs_dat_i[0];
      clr   = wr && reg_i == 2 && wbs_dat_i[1];
      if (rd) begin
        case (reg_i)
          0:       m_exp_dat = (sz > 0) ? m_q[0] : 32'h0;
          1:       m_exp_dat = model_status(sz, m_uf);
          3:       m_exp_dat = m_total;
          default: m_exp_dat = 32'h0;
        endcase
      end
      pop  = rd && reg_i == 0 && sz > 0;
      push = rts_i && sz < DEPTH && !flush;
      if (rd && reg_i == 0 && sz == 0) m_uf = 1;
      else if (clr)                    m_uf = 0;
      if (flush) m_q.delete();
      else begin
        if (pop)  void'(m_q.pop_front());
        if (push) m_q.push_back(data_i);
      end
      if (push) m_total = m_total + 1;
      m_ack    = req;
      m_exp_rd = rd;
    end
  end

  // Per-cycle comparison against the model, sampled 1ns after the edge
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      check("ack", 32'(wbs_ack_o), 32'(m_ack));
      check("rtr", 32'(rtr_o), 32'(m_q.size() != DEPTH));
      if (m_ack && m_exp_rd) check("model_rd_data", wbs_dat_o, m_exp_dat);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push(input logic [31:0] d);
    rts_i  = 1'b1;
    data_i = d;
    @(posedge clk); #1;
    rts_i  = 1'b0;
  endtask

  // Returns 1ns after the ack edge with strobes already dropped
  task automatic wb(input logic we, input logic [3:0] adr, input logic [31:0] wdat,
                    output logic [31:0] rdat);
    bit got;
    got       = 0;
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = we;
    wbs_adr_i = adr;
    wbs_dat_i = wdat;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk); #1;
      if (wbs_ack_o) got = 1;
    end
    rdat      = wbs_dat_o;
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
    if (!got) check("wb_ack_timeout", 32'(got), 32'd1);
  endtask

  // One idle cycle, then a request and a push landing on the same accept edge
  task automatic wb_with_push(input logic we, input logic [3:0] adr, input logic [31:0] wdat,
                              input logic [31:0] pdat, output logic [31:0] rdat);
    @(posedge clk); #1;
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = we;
    wbs_adr_i = adr;
    wbs_dat_i = wdat;
    rts_i     = 1'b1;
    data_i    = pdat;
    @(posedge clk); #1;
    rts_i     = 1'b0;
    check("wbp_ack", 32'(wbs_ack_o), 32'd1);
    rdat      = wbs_dat_o;
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          is_wb;
    bit          we;
    logic [3:0]  adr;
    logic [31:0] wdat;
    logic [31:0] exp;
    bit          chk;
    string       name;
  } vec_t;

  vec_t vq [$];

  task automatic add(input bit is_wb, input bit we, input logic [3:0] adr,
                     input logic [31:0] wdat, input logic [31:0] exp, input bit chk,
                     input string name);
    vec_t v;
    v.is_wb = is_wb; v.we = we; v.adr = adr; v.wdat = wdat;
    v.exp = exp; v.chk = chk; v.name = name;
    vq.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;

    rst_n = 0; rts_i = 0; data_i = 0;
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
    wbs_sel_i = 4'hF; wbs_adr_i = 0; wbs_dat_i = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ack", 32'(wbs_ack_o), 32'd0);
    check("reset_dat", wbs_dat_o, 32'd0);
    check("reset_rtr", 32'(rtr_o), 32'd1);
    rst_n = 1;

    add(1, 0, 4'h4, 0,       32'h0000_0080, 1, "reset_status");
    add(0, 0, 0,    32'h11,  0,             0, "push");
    add(0, 0, 0,    32'h22,  0,             0, "push");
    add(0, 0, 0,    32'h33,  0,             0, "push");
    add(1, 0, 4'h0, 0,       32'h11,        1, "pop_1");
    add(1, 0, 4'h0, 0,       32'h22,        1, "pop_2");
    add(1, 0, 4'h0, 0,       32'h33,        1, "pop_3");
    add(1, 0, 4'h4, 0,       32'h0000_0080, 1, "status_empty");
    add(1, 0, 4'hC, 0,       32'd3,         1, "total_3");
    add(1, 0, 4'h0, 0,       32'h0,         1, "underflow_read");
    add(1, 0, 4'h4, 0,       32'h0000_8080, 1, "status_underflow");
    add(1, 1, 4'h8, 32'h2,   0,             0, "clr_underflow");
    add(1, 0, 4'h4, 0,       32'h0000_0080, 1, "status_uf_cleared");
    add(1, 0, 4'h8, 0,       32'h0,         1, "ctrl_reads_zero");
    add(1, 1, 4'h0, 32'hDEAD, 0,            0, "write_data_ro");
    add(1, 1, 4'hC, 32'hBEEF, 0,            0, "write_total_ro");
    add(1, 0, 4'hC, 0,       32'd3,         1, "total_after_ro_writes");
    add(1, 0, 4'h4, 0,       32'h0000_0080, 1, "status_after_ro_writes");

    foreach (vq[i]) begin
      if (vq[i].is_wb) begin
        wb(vq[i].we, vq[i].adr, vq[i].wdat, r);
        if (vq[i].chk) check(vq[i].name, r, vq[i].exp);
      end else begin
        push(vq[i].wdat);
      end
    end

    // Fill: rts held for 10 cycles, only 8 words fit
    for (int i = 0; i < 10; i++) begin
      data_i = 32'h100 + 32'(i);
      rts_i  = 1'b1;
      @(posedge clk); #1;
    end
    rts_i = 1'b0;
    check("full_rtr_low", 32'(rtr_o), 32'd0);
    wb(0, 4'h4, 0, r); check("status_full", r, 32'h0000_0108);
    wb(0, 4'hC, 0, r); check("total_11", r, 32'd11);
    wb(0, 4'h0, 0, r); check("pop_from_full", r, 32'h100);
    check("rtr_after_pop", 32'(rtr_o), 32'd1);
    push(32'h108);
    check("rtr_refilled", 32'(rtr_o), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      wb(0, 4'h0, 0, r); check("drain_order", r, 32'h100 + 32'(i));
    end
    wb(0, 4'h4, 0, r); check("status_drained", r, 32'h0000_0080);
    wb(0, 4'hC, 0, r); check("total_12", r, 32'd12);

    // Flush with a simultaneous push: push discarded, TOTAL untouched
    for (int i = 0; i < 5; i++) push(32'h200 + 32'(i));
    wb_with_push(1, 4'h8, 32'h1, 32'hBAD, r);
    wb(0, 4'h4, 0, r); check("status_flushed", r, 32'h0000_0080);
    wb(0, 4'hC, 0, r); check("total_17", r, 32'd17);

    // Push+pop together at DEPTH-1 across pointer wrap
    for (int i = 0; i < 7; i++) push(32'h300 + 32'(i));
    for (int k = 0; k < 20; k++) begin
      wb_with_push(0, 4'h0, 0, 32'h307 + 32'(k), r);
      check("wrap_order", r, 32'h300 + 32'(k));
    end
    wb(0, 4'h4, 0, r); check("status_wrap", r, 32'h0000_0007);
    wb(0, 4'hC, 0, r); check("total_44", r, 32'd44);

    // Randomized traffic, checked by the model every cycle
    for (int n = 0; n < 300; n++) begin
      rts_i  = 1'($urandom_range(0, 1));
      data_i = $urandom;
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk); #1;
      end else begin
        logic        we;
        logic [31:0] wd;
        we = ($urandom_range(0, 3) == 0);
        wd = {30'h0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) == 0)};
        wb(we, {2'($urandom_range(0, 3)), 2'b00}, wd, r);
      end
    end
    rts_i = 1'b0;

    // Reset in the middle of a transaction
    push(32'hA1); push(32'hA2);
    @(posedge clk); #1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 4'h4;
    @(posedge clk); #1;
    check("pre_reset_ack", 32'(wbs_ack_o), 32'd1);
    #2 rst_n = 0;
    #1;
    check("reset_drops_ack", 32'(wbs_ack_o), 32'd0);
    check("reset_rtr_high", 32'(rtr_o), 32'd1);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    @(posedge clk); #2 rst_n = 1;
    @(posedge clk); #1;
    wb(0, 4'h4, 0, r); check("status_after_reset", r, 32'h0000_0080);
    wb(0, 4'hC, 0, r); check("total_after_reset", r, 32'd0);

    @(posedge clk); #2;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
